lcd_sequencer: RTL and testbench
================================

Name: lcd_sequencer

Overview:
- Front-end controller for the 4-bit-bus LCD nibble writer (27 MHz system).
- Runs the HD44780 power-up/init sequence, then serves one host port: characters (RS=1) and raw commands (RS=0).
- Tracks the cursor on a 16x2 display and inserts DDRAM-address commands automatically on line wrap.
- Each transfer is one Strb pulse to the writer; the block then follows the writer's Busy handshake.

Parameters:
- PwrUpDly, 540000: cycles to wait after reset before the first init command (20 ms @ 27 MHz).
- AckTimeout, 4: cycles to wait for Busy to rise after Strb before re-strobing.
- NumCols, 16: characters per line; wrap threshold.

Ports:
- Clk  input  1  system clock, 27 MHz; all state on posedge.
- Reset  input  1  asynchronous, active-high; clears all state, restarts power-up.
- Busy  input  1  writer busy flag; rises after an accepted Strb, falls when the writer's 2 ms delay ends.
- Host_valid  input  1  host request valid.
- Host_rs  input  1  1 = character, 0 = command.
- Host_data  input  8  character code or command byte.
- Host_ready  output  1  high only in IDLE; transfer occurs when Host_valid & Host_ready.
- Strb  output  1  one-cycle strobe to the writer.
- Lcd_data  output  8  byte to the writer; held stable from Strb until Busy falls.
- Lcd_rs  output  1  RS to the writer; same hold rule.
- Init_done  output  1  set after the last init command completes; cleared only by Reset.
- Col  output  4  current cursor column, 0..NumCols-1.
- Line  output  1  current cursor line, 0/1.

Behaviour:
- Reset values: Strb=0, Lcd_data=0, Lcd_rs=0, Host_ready=0, Init_done=0, Col=0, Line=0. FSM enters PWRUP; delay counter cleared.
- Reset mid-transfer: everything is abandoned and the full init sequence reruns. The writer is reset by the same signal.
- States: PWRUP, ISSUE, WAIT_HI, WAIT_LO, IDLE.
- PWRUP: counter increments each cycle. When it equals PwrUpDly-1, go to ISSUE with init index 0.
- Init ROM, 6 entries, RS=0, issued in order: 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01.
- ISSUE (one cycle):
  - Strb=1; Lcd_data/Lcd_rs driven from the pending byte.
  - Pending byte comes from the ROM, the latched host byte, or the wrap command.
  - Next state: WAIT_HI; ack counter cleared.
- WAIT_HI:
  - Busy=1 → WAIT_LO.
  - Otherwise the ack counter increments. At AckTimeout, return to ISSUE and re-strobe the same byte.
- WAIT_LO: on Busy=0, the transfer is complete. Then, in priority order:
  1. Init not finished: advance the index and go to ISSUE. After entry 5, set Init_done, Col=0, Line=0, go to IDLE.
  2. A wrap command was just sent: go to IDLE.
  3. Completed character and Col==NumCols-1: Col=0, Line=~Line. Queue wrap command (0xC0 if the new Line=1, else 0x80; RS=0). Go to ISSUE.
  4. Completed character otherwise: Col=Col+1, go to IDLE.
  5. Completed command 0x01 or 0x02: Col=0, Line=0. Command with bit7=1: Line=data[6], Col=data[3:0]. Any other command: cursor unchanged. Go to IDLE.
- IDLE:
  - Host_ready=1.
  - On Host_valid: latch Host_rs/Host_data, deassert Host_ready, go to ISSUE next cycle.
  - Host request to ISSUE latency: 1 cycle.
  - Host_valid while not ready is ignored, and nothing is queued. The host must hold Host_valid.
- Col/Line update on completion, not on issue. Col wraps only through rule 3 and never reaches 16.
- Busy already high when entering WAIT_HI counts as acknowledge.
- Busy stuck high: the block waits in WAIT_LO indefinitely. There is no timeout there.

Decomposition:
- Shared package lcd_pkg:
  - State encoding.
  - Init ROM contents and length.
  - Command constants: CLEAR=0x01, HOME=0x02, DDRAM_L0=0x80, DDRAM_L1=0xC0.
  - The 27 MHz timing constants shared with the writer.
- One natural sub-module: lcd_init_rom. Combinational index-to-byte, 3-bit index.
- Delay and ack counters stay inline.

Test Plan:
- Power-up: Reset pulse, PwrUpDly=100, writer model Busy=1 for 20 cycles after each Strb. Expect first Strb exactly 100 cycles after Reset release. Expect 6 strobes with data 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01, all RS=0. Then Init_done=1, Host_ready=1.
- Char write: after init, send Host_rs=1, Host_data=0x41. Expect Strb 1 cycle after accept, Lcd_data=0x41, Lcd_rs=1. Expect Host_ready low until Busy falls, then Col=1.
- Wrap: write 16 chars. After the 16th completes, expect an automatic Strb with 0xC0 RS=0, then Col=0, Line=1. After 16 more, expect 0x80 and Line=0.
- Cursor commands: send command 0xC5 → Line=1, Col=5. Send 0x01 → Col=0, Line=0. Send 0x0E → Col/Line unchanged.
- Ack timeout: writer model ignores the first Strb. Expect a re-strobe AckTimeout=4 cycles later with identical Lcd_data.
- Reset mid-operation: assert Reset while in WAIT_LO. Expect all outputs 0 immediately (async), Init_done=0, and the init sequence restarting after PwrUpDly.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD front end: FSM states,
// init sequence, command bytes and 27 MHz timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    IDLE
  } state_t;

  localparam int unsigned CLK_HZ      = 27_000_000;
  localparam int unsigned PWRUP_CYCLES = (CLK_HZ / 1000) * 20;

  localparam int unsigned INIT_LEN = 6;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_DDRAM_L0 = 8'h80;
  localparam logic [7:0] CMD_DDRAM_L1 = 8'hC0;

  function automatic logic [7:0] init_rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h33;
      3'd1:    return 8'h32;
      3'd2:    return 8'h28;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h06;
      3'd5:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the HD44780 power-up command sequence.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] data
);

  always_comb begin
    data = init_rom_byte(idx);
  end

endmodule

// File: rtl/lcd_sequencer.sv
// LCD front-end controller: power-up init, host character/command port,
// cursor tracking with automatic DDRAM re-addressing on line wrap.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned PwrUpDly   = PWRUP_CYCLES,
  parameter int unsigned AckTimeout = 4,
  parameter int unsigned NumCols    = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Busy,
  input  logic       Host_valid,
  input  logic       Host_rs,
  input  logic [7:0] Host_data,
  output logic       Host_ready,
  output logic       Strb,
  output logic [7:0] Lcd_data,
  output logic       Lcd_rs,
  output logic       Init_done,
  output logic [3:0] Col,
  output logic       Line
);

  localparam int unsigned DW = (PwrUpDly > 1) ? $clog2(PwrUpDly) : 1;
  localparam int unsigned AW = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(PwrUpDly - 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(AckTimeout - 1);
  localparam logic [3:0]    COL_LAST = 4'(NumCols - 1);
  localparam logic [2:0]    IDX_LAST = 3'(INIT_LEN - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [AW-1:0] ack_q, ack_d;
  logic [2:0]    idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    col_q, col_d;
  logic          line_q, line_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          strb;

  logic [2:0] rom_idx;
  logic [7:0] rom_data;

  // ROM is addressed with the entry about to be loaded, derived from flops only.
  assign rom_idx = (state_q == WAIT_LO) ? idx_q + 3'd1 : 3'd0;

  lcd_init_rom u_rom (
    .idx  (rom_idx),
    .data (rom_data)
  );

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    ack_d       = ack_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    wrap_d      = wrap_q;
    col_d       = col_q;
    line_d      = line_q;
    data_d      = data_q;
    rs_d        = rs_q;
    strb        = 1'b0;

    case (state_q)
      PWRUP: begin
        dly_d = dly_q + DW'(1);
        if (dly_q == DLY_LAST) begin
          dly_d   = '0;
          idx_d   = '0;
          data_d  = rom_data;
          rs_d    = 1'b0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        strb    = 1'b1;
        ack_d   = '0;
        state_d = WAIT_HI;
      end

      WAIT_HI: begin
        if (Busy) begin
          state_d = WAIT_LO;
        end else begin
          // The strobe cycle counts toward the timeout, so re-strobes land
          // exactly AckTimeout cycles apart.
          ack_d = ack_q + AW'(1);
          if (ack_d == ACK_LAST) state_d = ISSUE;
        end
      end

      WAIT_LO: begin
        if (!Busy) begin
          if (!init_done_q) begin
            if (idx_q == IDX_LAST) begin
              init_done_d = 1'b1;
              col_d       = '0;
              line_d      = 1'b0;
              state_d     = IDLE;
            end else begin
              idx_d   = idx_q + 3'd1;
              data_d  = rom_data;
              rs_d    = 1'b0;
              state_d = ISSUE;
            end
          end else if (wrap_q) begin
            wrap_d  = 1'b0;
            state_d = IDLE;
          end else if (rs_q) begin
            if (col_q == COL_LAST) begin
              col_d   = '0;
              line_d  = ~line_q;
              wrap_d  = 1'b1;
              data_d  = line_q ? CMD_DDRAM_L0 : CMD_DDRAM_L1;
              rs_d    = 1'b0;
              state_d = ISSUE;
            end else begin
              col_d   = col_q + 4'd1;
              state_d = IDLE;
            end
          end else begin
            if (data_q == CMD_CLEAR || data_q == CMD_HOME) begin
              col_d  = '0;
              line_d = 1'b0;
            end else if (data_q[7]) begin
              line_d = data_q[6];
              col_d  = data_q[3:0];
            end
            state_d = IDLE;
          end
        end
      end

      IDLE: begin
        if (Host_valid) begin
          data_d  = Host_data;
          rs_d    = Host_rs;
          state_d = ISSUE;
        end
      end

      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= PWRUP;
      dly_q       <= '0;
      ack_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      wrap_q      <= 1'b0;
      col_q       <= '0;
      line_q      <= 1'b0;
      data_q      <= '0;
      rs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      ack_q       <= ack_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      wrap_q      <= wrap_d;
      col_q       <= col_d;
      line_q      <= line_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
    end
  end

  assign Strb       = strb;
  assign Host_ready = (state_q == IDLE);
  assign Lcd_data   = data_q;
  assign Lcd_rs     = rs_q;
  assign Init_done  = init_done_q;
  assign Col        = col_q;
  assign Line       = line_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a writer model and a strobe scoreboard.
module tb_lcd_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Busy;
  logic       Host_valid;
  logic       Host_rs;
  logic [7:0] Host_data;
  logic       Host_ready;
  logic       Strb;
  logic [7:0] Lcd_data;
  logic       Lcd_rs;
  logic       Init_done;
  logic [3:0] Col;
  logic       Line;

  lcd_sequencer #(
    .PwrUpDly   (100),
    .AckTimeout (4),
    .NumCols    (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Busy       (Busy),
    .Host_valid (Host_valid),
    .Host_rs    (Host_rs),
    .Host_data  (Host_data),
    .Host_ready (Host_ready),
    .Strb       (Strb),
    .Lcd_data   (Lcd_data),
    .Lcd_rs     (Lcd_rs),
    .Init_done  (Init_done),
    .Col        (Col),
    .Line       (Line)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strb_total = 0;
  int last_strb_cyc = 0;
  int prev_strb_cyc = 0;
  int rel_cyc = 0;
  int ignore_req = 0;
  int ignored_cnt = 0;
  int busy_cnt = 0;
  logic [8:0] sb[$];
  logic [3:0] exp_col = '0;
  logic       exp_line = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Writer model: Busy for 20 cycles after each accepted strobe; can drop one strobe on request.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Busy     <= 1'b0;
      busy_cnt <= 0;
    end else if (Strb && !Busy) begin
      if (ignore_req != ignored_cnt) begin
        ignored_cnt <= ignored_cnt + 1;
      end else begin
        Busy     <= 1'b1;
        busy_cnt <= 19;
      end
    end else if (Busy) begin
      if (busy_cnt == 0) Busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  always @(negedge Clk) begin
    if (!Reset && Strb) begin
      logic [8:0] e;
      strb_total++;
      prev_strb_cyc = last_strb_cyc;
      last_strb_cyc = cyc;
      check("sb_entry_available", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strb_data", 32'(Lcd_data), 32'(e[7:0]));
        check("strb_rs", 32'(Lcd_rs), 32'(e[8]));
      end
    end
  end

  task automatic push_init();
    logic [7:0] rom [6];
    rom = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 6; i++) sb.push_back({1'b0, rom[i]});
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      if (Host_ready) break;
      @(negedge Clk);
    end
  endtask

  task automatic model_update(input logic rs, input logic [7:0] d);
    if (rs) begin
      if (exp_col == 4'd15) begin
        exp_col  = '0;
        exp_line = ~exp_line;
        sb.push_back({1'b0, exp_line ? 8'hC0 : 8'h80});
      end else begin
        exp_col = exp_col + 4'd1;
      end
    end else if (d == 8'h01 || d == 8'h02) begin
      exp_col  = '0;
      exp_line = 1'b0;
    end else if (d[7]) begin
      exp_line = d[6];
      exp_col  = d[3:0];
    end
  endtask

  task automatic drive_req(input logic rs, input logic [7:0] d);
    wait_ready();
    check("ready_before_send", 32'(Host_ready), 1);
    Host_valid = 1'b1;
    Host_rs    = rs;
    Host_data  = d;
    sb.push_back({rs, d});
    model_update(rs, d);
    @(posedge Clk);
    #1 Host_valid = 1'b0;
    @(negedge Clk);
    check("strb_latency", 32'(Strb), 1);
    check("ready_low_after_accept", 32'(Host_ready), 0);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    drive_req(rs, d);
    wait_ready();
    check("ready_after_done", 32'(Host_ready), 1);
    check("col", 32'(Col), 32'(exp_col));
    check("line", 32'(Line), 32'(exp_line));
  endtask

  task automatic release_and_init();
    int base;
    base = strb_total;
    @(negedge Clk);
    Reset = 1'b0;
    rel_cyc = cyc;
    for (int i = 0; i < 300; i++) begin
      if (strb_total > base) break;
      @(negedge Clk);
    end
    check("first_strb_delay", 32'(last_strb_cyc - rel_cyc), 100);
    for (int i = 0; i < 2000; i++) begin
      if (Init_done) break;
      @(negedge Clk);
    end
    check("init_done", 32'(Init_done), 1);
    check("init_strobes", 32'(strb_total - base), 6);
    @(negedge Clk);
    check("ready_after_init", 32'(Host_ready), 1);
    check("init_col", 32'(Col), 0);
    check("init_line", 32'(Line), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strb"}, 32'(Strb), 0);
    check({tag, "_data"}, 32'(Lcd_data), 0);
    check({tag, "_rs"}, 32'(Lcd_rs), 0);
    check({tag, "_ready"}, 32'(Host_ready), 0);
    check({tag, "_init_done"}, 32'(Init_done), 0);
    check({tag, "_col"}, 32'(Col), 0);
    check({tag, "_line"}, 32'(Line), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b1;
    Host_valid = 1'b0;
    Host_rs    = 1'b0;
    Host_data  = '0;
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    push_init();
    release_and_init();

    // Single character
    send(1'b1, 8'h41);

    // Home to column 0 line 0, then fill both lines to exercise both wrap commands
    send(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 8'(8'h61 + i));
      if (i == 14) check("col_before_wrap", 32'(Col), 15);
    end
    check("wrap1_line", 32'(Line), 1);
    check("wrap1_col", 32'(Col), 0);
    for (int i = 0; i < 16; i++) send(1'b1, 8'(8'h30 + i));
    check("wrap2_line", 32'(Line), 0);
    check("wrap2_col", 32'(Col), 0);

    // Cursor commands
    send(1'b0, 8'hC5);
    check("cmd_c5", 32'({Line, Col}), 32'({1'b1, 4'd5}));
    send(1'b0, 8'h0E);
    check("cmd_0e", 32'({Line, Col}), 32'({1'b1, 4'd5}));
    send(1'b0, 8'h01);
    check("cmd_01", 32'({Line, Col}), 0);
    send(1'b0, 8'h83);
    send(1'b0, 8'h02);
    check("cmd_02", 32'({Line, Col}), 0);

    // Writer drops the first strobe: same byte re-strobed AckTimeout cycles later
    ignore_req = ignore_req + 1;
    sb.push_back({1'b1, 8'h55});
    send(1'b1, 8'h55);
    check("restrobe_gap", 32'(last_strb_cyc - prev_strb_cyc), 4);

    // Reset while the writer is busy
    drive_req(1'b1, 8'h66);
    for (int i = 0; i < 50; i++) begin
      if (Busy) break;
      @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
    check("hold_data", 32'(Lcd_data), 32'h66);
    check("hold_rs", 32'(Lcd_rs), 1);
    #2 Reset = 1'b1;
    #1 check_all_zero("midreset");
    sb.delete();
    exp_col  = '0;
    exp_line = 1'b0;
    push_init();
    repeat (2) @(negedge Clk);
    release_and_init();
    send(1'b1, 8'h42);

    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
